// File: rtl/coin_feeder_pkg.sv
// coin_feeder_pkg: shared types and constants for the coin feeder block.
//   state_e          - controller state encoding
//   PAY_FIFTY/DOLLAR - captured pay_mode values
//   TIMEOUT_DEFAULT  - default WAIT_RES timeout in cycles
//   coin_inc         - saturating (at 2) coin counter increment
package coin_feeder_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWaitRdy,
      StCoin1,
      StGap,
      StCoin2,
      StWaitRes,
      StCancel
   } state_e;

   localparam logic PAY_FIFTY  = 1'b0;
   localparam logic PAY_DOLLAR = 1'b1;

   localparam int unsigned TIMEOUT_DEFAULT = 8;

   function automatic logic [1:0] coin_inc(input logic [1:0] cnt);
      return (cnt >= 2'd2) ? 2'd2 : cnt + 2'd1;
   endfunction

endpackage

// File: rtl/feeder_wait_timer.sv
// feeder_wait_timer: 4-bit clearable cycle counter with terminal-count flag.
//   clk, rst_n - clock, synchronous active-low reset
//   clr        - zero the counter (has priority over en)
//   en         - count this cycle
//   tc         - high on the LIMIT-th enabled cycle since the last clear
module feeder_wait_timer
   import coin_feeder_pkg::*;
#(
   parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [3:0] LastCount = 4'(LIMIT - 1);

   logic [3:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= 4'd0;
      end else if (clr) begin
         cnt_q <= 4'd0;
      end else if (en && cnt_q != 4'hF) begin
         cnt_q <= cnt_q + 4'd1;
      end
   end

   // cnt_q counts cycles already spent, so LIMIT-1 marks the LIMIT-th cycle
   assign tc = en && (cnt_q == LastCount);

endmodule

// File: rtl/coin_feeder.sv
// coin_feeder: drives coin pulses to a vendor for one purchase and reports the outcome.
//   clk, rst_n                         - clock, synchronous active-low reset
//   buy, pay_mode, abort               - customer request, 0 = 2x fifty / 1 = dollar, cancel
//   insert_coin, money_return, dispense - vendor status lines
//   fifty, dollar, cancel              - registered one-cycle pulses to the vendor
//   busy                               - high whenever not idle
//   done, refunded, timeout_err        - registered one-cycle completion pulses
//   coins_in                           - coins delivered in the current transaction
// Build option: define COIN_FEEDER_TIMEOUT_EN to abandon WAIT_RES after TIMEOUT cycles;
// otherwise WAIT_RES waits indefinitely and timeout_err is tied low.
module coin_feeder
   import coin_feeder_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       buy,
   input  logic       pay_mode,
   input  logic       abort,
   input  logic       insert_coin,
   input  logic       money_return,
   input  logic       dispense,
   output logic       fifty,
   output logic       dollar,
   output logic       cancel,
   output logic       busy,
   output logic       done,
   output logic       refunded,
   output logic       timeout_err,
   output logic [1:0] coins_in
);

   if (TIMEOUT < 2 || TIMEOUT > 15) begin : g_bad_timeout
      $error("coin_feeder: TIMEOUT must be in 2..15");
   end

   state_e     state_q, state_d;
   logic       mode_q, mode_d;
   logic [1:0] coins_q, coins_d;
   logic       fifty_q, fifty_d;
   logic       dollar_q, dollar_d;
   logic       cancel_q, cancel_d;
   logic       done_q, done_d;
   logic       refunded_q, refunded_d;
   logic       busy_q;
   logic       expire;

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      coins_d    = coins_q;
      done_d     = 1'b0;
      refunded_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (buy) begin
               state_d = StWaitRdy;
               mode_d  = pay_mode;
               coins_d = 2'd0;
            end
         end
         StWaitRdy: begin
            if (abort) begin
               state_d = StIdle;
            end else if (insert_coin) begin
               state_d = StCoin1;
            end
         end
         StCoin1:   state_d = (mode_q == PAY_DOLLAR) ? StWaitRes : StGap;
         StGap:     state_d = abort ? StCancel : StCoin2;
         StCoin2:   state_d = StWaitRes;
         StCancel:  state_d = StWaitRes;
         StWaitRes: begin
            if (dispense) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end else if (money_return) begin
               state_d    = StIdle;
               refunded_d = 1'b1;
            end else if (expire) begin
               state_d = StIdle;
            end
         end
         default:   state_d = StIdle;
      endcase

      // Vendor pulses are decoded from the next state so they line up with the state itself
      fifty_d  = (state_d == StCoin1 && mode_q == PAY_FIFTY) || (state_d == StCoin2);
      dollar_d = (state_d == StCoin1 && mode_q == PAY_DOLLAR);
      cancel_d = (state_d == StCancel);
      if (state_d == StCoin1 || state_d == StCoin2) begin
         coins_d = coin_inc(coins_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         mode_q     <= PAY_FIFTY;
         coins_q    <= 2'd0;
         fifty_q    <= 1'b0;
         dollar_q   <= 1'b0;
         cancel_q   <= 1'b0;
         done_q     <= 1'b0;
         refunded_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         coins_q    <= coins_d;
         fifty_q    <= fifty_d;
         dollar_q   <= dollar_d;
         cancel_q   <= cancel_d;
         done_q     <= done_d;
         refunded_q <= refunded_d;
         busy_q     <= (state_d != StIdle);
      end
   end

`ifdef COIN_FEEDER_TIMEOUT_EN
   logic timeout_q;

   feeder_wait_timer #(
      .LIMIT (TIMEOUT)
   ) u_wait_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state_q != StWaitRes),
      .en    (state_q == StWaitRes),
      .tc    (expire)
   );

   // A vendor result on the expiry cycle takes precedence over the timeout
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= (state_q == StWaitRes) && !dispense && !money_return && expire;
      end
   end

   assign timeout_err = timeout_q;
`else
   assign expire      = 1'b0;
   assign timeout_err = 1'b0;
`endif

   assign fifty    = fifty_q;
   assign dollar   = dollar_q;
   assign cancel   = cancel_q;
   assign done     = done_q;
   assign refunded = refunded_q;
   assign busy     = busy_q;
   assign coins_in = coins_q;

endmodule

// File: doc/coin_feeder.md
COIN_FEEDER -- requirements
Module: coin_feeder

Interface
REQ-001 Parameter: TIMEOUT, default 8, cycles to wait for a vendor result before timeout (range 2..15).
REQ-002 clk  input  1  single clock, all logic on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 buy  input  1  start-purchase request, sampled only in IDLE.
REQ-005 pay_mode  input  1  0 = two fifty-cent coins, 1 = one dollar; captured with buy.
REQ-006 abort  input  1  customer cancel request, level-sensitive.
REQ-007 insert_coin, money_return, dispense  input  1 each  vendor status lines.
REQ-008 fifty, dollar, cancel  output  1 each  registered one-cycle pulses to the vendor.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done, refunded, timeout_err  output  1 each  registered one-cycle completion pulses.
REQ-011 coins_in  output  2  coins delivered in the current transaction.

Function
REQ-012 States SHALL be IDLE, WAIT_RDY, COIN1, GAP, COIN2, WAIT_RES, CANCEL.
REQ-013 IDLE: buy=1 SHALL capture pay_mode, clear coins_in and go to WAIT_RDY next cycle.
REQ-014 WAIT_RDY: insert_coin=1 SHALL go to COIN1, and abort=1 SHALL go to IDLE with no pulse and no completion pulse; abort wins if both are true.
REQ-015 COIN1: the block SHALL pulse dollar (mode 1) or fifty (mode 0) for exactly one cycle and increment coins_in.
REQ-016 After COIN1, mode 1 SHALL go to WAIT_RES and mode 0 SHALL go to GAP.
REQ-017 GAP lasts one cycle so the vendor can register the first coin.
REQ-018 From GAP, abort=1 SHALL go to CANCEL; otherwise the block SHALL go to COIN2.
REQ-019 COIN2 SHALL pulse fifty for one cycle, increment coins_in and go to WAIT_RES.
REQ-020 CANCEL SHALL pulse cancel for one cycle and go to WAIT_RES.
REQ-021 WAIT_RES: dispense=1 SHALL pulse done and go to IDLE.
REQ-022 WAIT_RES: money_return=1 SHALL pulse refunded and go to IDLE.
REQ-023 WAIT_RES: if dispense and money_return are both 1, dispense SHALL take priority.
REQ-024 abort SHALL be ignored in COIN1, COIN2, CANCEL and WAIT_RES.
REQ-025 fifty, dollar and cancel SHALL be mutually exclusive and never asserted in two consecutive cycles.
REQ-026 coins_in SHALL saturate at 2 and SHALL hold its value after completion until the next buy.

Reset
REQ-027 rst_n=0 at a clock edge SHALL force IDLE, including mid-transaction.
REQ-028 Reset SHALL clear all pulse outputs, busy, coins_in, the captured mode and the timer.
REQ-029 The first state transition SHALL occur at the first edge with rst_n=1.

Configuration
REQ-030 The macro COIN_FEEDER_TIMEOUT_EN SHALL control the timeout feature.
REQ-031 With COIN_FEEDER_TIMEOUT_EN defined, the timer SHALL count cycles spent in WAIT_RES.
REQ-032 With COIN_FEEDER_TIMEOUT_EN defined, reaching TIMEOUT cycles in WAIT_RES SHALL pulse timeout_err and return to IDLE; a result arriving on the expiry cycle SHALL win.
REQ-033 Without COIN_FEEDER_TIMEOUT_EN, WAIT_RES SHALL wait indefinitely and timeout_err SHALL be tied to 0.

Structure
REQ-034 A shared package coin_feeder_pkg SHALL hold the state enumeration, the pay-mode constants (PAY_FIFTY=0, PAY_DOLLAR=1) and the default TIMEOUT.
REQ-035 One sub-module, feeder_wait_timer, SHALL implement the 4-bit clearable cycle counter with terminal-count output, instantiated only under COIN_FEEDER_TIMEOUT_EN.

Verification
REQ-036 Dollar purchase: buy=1, pay_mode=1, insert_coin=1, then dispense=1 two cycles after the dollar pulse -> dollar pulses once, done pulses once, coins_in=1, busy low afterwards.
REQ-037 Two-fifty purchase: pay_mode=0 -> fifty pulses are exactly 2 cycles apart (rising edge to rising edge, COIN1 then GAP then COIN2), dispense then gives done, coins_in=2.
REQ-038 Abort after first fifty: abort=1 during GAP -> no second fifty, cancel pulses once, money_return=1 gives refunded, coins_in=1.
REQ-039 Abort in WAIT_RDY with insert_coin=1 on the same cycle -> no coin pulse, return to IDLE, no done or refunded pulse.
REQ-040 Timeout (macro defined, TIMEOUT=8): no vendor response -> timeout_err pulses 8 cycles after entering WAIT_RES; with the macro undefined the block stays busy.
REQ-041 Reset mid-transaction: rst_n=0 one cycle after the first fifty pulse -> all outputs 0 at the next edge, state IDLE, no further pulses.
